// File: rtl/hazard_controller.sv
// hazard_controller
//   Pipeline sequencer for a 5-stage RV32I datapath. It produces the operand
//   forwarding selects, the load-use stall, the branch/jump flushes and a
//   whole-pipeline freeze while the data memory has not acknowledged. A
//   memory access that stays unacknowledged for too long traps into a sticky
//   error state. Two saturating counters track stall and flush cycles.
//
// Ports
//   clk, rst_n             clock, synchronous active-low reset
//   Rs1D, Rs2D             source registers of the instruction in Decode
//   Rs1E, Rs2E             source registers of the instruction in Execute
//   RdE, RdM, RdW          destination registers in Execute / Memory / Writeback
//   ResultSrcE             result select in Execute, bit 0 marks a load
//   PCSrcE                 taken branch or jump resolved in Execute
//   RegWriteM, RegWriteW   M / W instruction writes the register file
//   MemAccessM             M instruction is a load or store
//   mem_ready              data memory acknowledges the current access this cycle
//   cnt_clr                clear both performance counters
//   ForwardAE, ForwardBE   00 register file, 10 ALUResultM, 01 ResultW
//   StallF..StallW         per-stage hold (E/M/W only during a freeze)
//   FlushD, FlushE         clear F/D and D/E registers
//   mem_req                data memory request strobe
//   bus_err                sticky memory-timeout flag
//   stall_cnt, flush_cnt   saturating counts of StallF / FlushD cycles
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal flow; an unacknowledged access freezes and enters MEM_WAIT
// MEM_WAIT | waiting for mem_ready; wait_cnt counts frozen cycles
// ERROR    | memory timed out; full freeze, no requests, until reset
module hazard_controller #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemAccessM,
  input  logic             mem_ready,
  input  logic             cnt_clr,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             StallW,
  output logic             FlushD,
  output logic             FlushE,
  output logic             mem_req,
  output logic             bus_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // wait_cnt must be able to hold MEM_TIMEOUT itself for the compare.
  localparam int unsigned WAIT_W = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
  localparam bit TIMEOUT_EN = (MEM_TIMEOUT != 0);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              lw_stall;
  logic              freeze;

  // Only bit 0 of ResultSrcE (load marker) matters here.
  logic unused;
  assign unused = ResultSrcE[1];

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (RegWriteM && (RdM != 5'd0) && (RdM == rs))
      return 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      ST_RUN: begin
        if (MemAccessM && !mem_ready) begin
          state_nxt    = ST_MEM_WAIT;
          wait_cnt_nxt = WAIT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          state_nxt    = ST_RUN;
          wait_cnt_nxt = '0;
        end else if (TIMEOUT_EN && (wait_cnt == WAIT_LIMIT)) begin
          state_nxt = ST_ERROR;
        end else if (wait_cnt != '1) begin
          // Saturate so a disabled timeout cannot wrap the counter.
          wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      ST_ERROR: begin
        state_nxt = ST_ERROR;
      end
      default: begin
        state_nxt    = ST_RUN;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  assign lw_stall = ResultSrcE[0] && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign freeze   = (((state == ST_RUN) || (state == ST_MEM_WAIT)) && MemAccessM && !mem_ready)
                    || (state == ST_ERROR);

  // Output logic; reset forces a flushed, unstalled, request-free pipeline.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    StallW    = 1'b0;
    FlushD    = 1'b1;
    FlushE    = 1'b1;
    mem_req   = 1'b0;
    bus_err   = (state == ST_ERROR);
    if (rst_n) begin
      ForwardAE = fwd_sel(Rs1E);
      ForwardBE = fwd_sel(Rs2E);
      StallF    = lw_stall || freeze;
      StallD    = lw_stall || freeze;
      StallE    = freeze;
      StallM    = freeze;
      StallW    = freeze;
      FlushD    = PCSrcE && !freeze;
      FlushE    = (lw_stall || PCSrcE) && !freeze;
      mem_req   = MemAccessM && (state != ST_ERROR);
    end
  end

  // Saturating performance counters; clear wins over increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (StallF && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (FlushD && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] ResultSrcE;
  logic       PCSrcE, RegWriteM, RegWriteW, MemAccessM, mem_ready, cnt_clr;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, mem_req, bus_err;
  logic [3:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_controller #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemAccessM(MemAccessM), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
    .FlushD(FlushD), .FlushE(FlushE), .mem_req(mem_req), .bus_err(bus_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // outs = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, mem_req, bus_err}
  typedef struct {
    string       name;
    logic [12:0] outs;
    bit          chk_cnt;
    logic [3:0]  scnt;
    logic [3:0]  fcnt;
  } exp_t;

  exp_t sb_q[$];
  int   passed = 0;
  int   total  = 0;

  exp_t        mon_e;
  logic [12:0] mon_act;

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e   = sb_q.pop_front();
      mon_act = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, StallW,
                 FlushD, FlushE, mem_req, bus_err};
      total++;
      if (mon_act === mon_e.outs) passed++;
      else $display("FAIL %s outputs: got %b required %b", mon_e.name, mon_act, mon_e.outs);
      if (mon_e.chk_cnt) begin
        total++;
        if (stall_cnt === mon_e.scnt && flush_cnt === mon_e.fcnt) passed++;
        else $display("FAIL %s counters: got stall=%0d flush=%0d required stall=%0d flush=%0d",
                      mon_e.name, stall_cnt, flush_cnt, mon_e.scnt, mon_e.fcnt);
      end
    end
  end

  task automatic expect_out(input string nm, input logic [1:0] fa, input logic [1:0] fb,
                            input logic [4:0] st, input logic fd, input logic fe,
                            input logic mr, input logic be, input bit cc,
                            input logic [3:0] sc, input logic [3:0] fc);
    exp_t e;
    e.name    = nm;
    e.outs    = {fa, fb, st, fd, fe, mr, be};
    e.chk_cnt = cc;
    e.scnt    = sc;
    e.fcnt    = fc;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE = 2'b00; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
    MemAccessM = 0; mem_ready = 0; cnt_clr = 0;
  endtask

  task automatic set_fwd(input logic [4:0] r1e, input logic [4:0] r2e, input logic [4:0] rdm,
                         input logic [4:0] rdw, input logic rwm, input logic rww);
    idle();
    Rs1E = r1e; Rs2E = r2e; RdM = rdm; RdW = rdw; RegWriteM = rwm; RegWriteW = rww;
  endtask

  task automatic set_lw();
    idle();
    ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
  endtask

  task automatic set_mem(input logic rdy, input logic br);
    idle();
    MemAccessM = 1; mem_ready = rdy; PCSrcE = br;
  endtask

  initial begin
    idle();
    rst_n = 0;
    tick();

    // reset forcing, with inputs that would otherwise forward/stall/request
    idle();
    RegWriteM = 1; RdM = 5; Rs1E = 5; MemAccessM = 1; ResultSrcE = 2'b01; RdE = 7; Rs1D = 7;
    expect_out("reset", 2'b00, 2'b00, 5'b00000, 1, 1, 0, 0, 1, 0, 0); tick();

    rst_n = 1;
    idle();
    expect_out("idle", 2'b00, 2'b00, 5'b00000, 0, 0, 0, 0, 1, 0, 0); tick();

    set_fwd(5, 0, 5, 5, 1, 1);
    expect_out("fwd_m", 2'b10, 2'b00, 5'b00000, 0, 0, 0, 0, 0, 0, 0); tick();
    set_fwd(5, 0, 5, 5, 0, 1);
    expect_out("fwd_w", 2'b01, 2'b00, 5'b00000, 0, 0, 0, 0, 0, 0, 0); tick();
    set_fwd(0, 0, 0, 0, 1, 1);
    expect_out("fwd_x0", 2'b00, 2'b00, 5'b00000, 0, 0, 0, 0, 0, 0, 0); tick();
    set_fwd(3, 5, 3, 5, 1, 1);
    expect_out("fwd_ab", 2'b10, 2'b01, 5'b00000, 0, 0, 0, 0, 0, 0, 0); tick();
    set_fwd(6, 6, 6, 6, 1, 1);
    expect_out("fwd_prio", 2'b10, 2'b10, 5'b00000, 0, 0, 0, 0, 0, 0, 0); tick();

    set_lw();
    expect_out("lw_stall", 2'b00, 2'b00, 5'b11000, 0, 1, 0, 0, 1, 0, 0); tick();
    idle(); ResultSrcE = 2'b01;
    expect_out("lw_x0", 2'b00, 2'b00, 5'b00000, 0, 0, 0, 0, 1, 1, 0); tick();
    idle(); ResultSrcE = 2'b10; RdE = 7; Rs1D = 7;
    expect_out("lw_notload", 2'b00, 2'b00, 5'b00000, 0, 0, 0, 0, 0, 0, 0); tick();

    idle(); PCSrcE = 1;
    expect_out("branch", 2'b00, 2'b00, 5'b00000, 1, 1, 0, 0, 1, 1, 0); tick();
    idle();
    expect_out("after_branch", 2'b00, 2'b00, 5'b00000, 0, 0, 0, 0, 1, 1, 1); tick();

    for (int i = 0; i < 3; i++) begin
      set_mem(0, 1);
      expect_out("mem_wait", 2'b00, 2'b00, 5'b11111, 0, 0, 1, 0, i == 0, 1, 1); tick();
    end
    set_mem(1, 0);
    expect_out("mem_done", 2'b00, 2'b00, 5'b00000, 0, 0, 1, 0, 1, 4, 1); tick();
    set_mem(1, 0);
    expect_out("zero_wait", 2'b00, 2'b00, 5'b00000, 0, 0, 1, 0, 1, 4, 1); tick();
    idle();
    expect_out("idle2", 2'b00, 2'b00, 5'b00000, 0, 0, 0, 0, 1, 4, 1); tick();

    // four unacknowledged cycles stay within MEM_TIMEOUT=4
    for (int i = 0; i < 4; i++) begin
      set_mem(0, 0);
      expect_out("wait4", 2'b00, 2'b00, 5'b11111, 0, 0, 1, 0, 0, 0, 0); tick();
    end
    set_mem(1, 0);
    expect_out("wait4_done", 2'b00, 2'b00, 5'b00000, 0, 0, 1, 0, 1, 8, 1); tick();
    idle();
    expect_out("no_err", 2'b00, 2'b00, 5'b00000, 0, 0, 0, 0, 1, 8, 1); tick();

    idle(); cnt_clr = 1;
    expect_out("clr", 2'b00, 2'b00, 5'b00000, 0, 0, 0, 0, 1, 8, 1); tick();
    for (int i = 0; i < 20; i++) begin
      set_lw();
      expect_out("sat", 2'b00, 2'b00, 5'b11000, 0, 1, 0, 0, 1, (i > 15) ? 4'd15 : 4'(i), 0);
      tick();
    end
    set_lw(); cnt_clr = 1;
    expect_out("clr_vs_inc", 2'b00, 2'b00, 5'b11000, 0, 1, 0, 0, 1, 15, 0); tick();
    idle();
    expect_out("cleared", 2'b00, 2'b00, 5'b00000, 0, 0, 0, 0, 1, 0, 0); tick();

    for (int i = 0; i < 5; i++) begin
      set_mem(0, 0);
      expect_out("to_wait", 2'b00, 2'b00, 5'b11111, 0, 0, 1, 0, 0, 0, 0); tick();
    end
    set_mem(0, 1);
    expect_out("error", 2'b00, 2'b00, 5'b11111, 0, 0, 0, 1, 0, 0, 0); tick();
    idle(); mem_ready = 1;
    expect_out("error_held", 2'b00, 2'b00, 5'b11111, 0, 0, 0, 1, 0, 0, 0); tick();
    idle(); MemAccessM = 1; rst_n = 0;
    expect_out("error_rst", 2'b00, 2'b00, 5'b00000, 1, 1, 0, 1, 1, 7, 0); tick();
    rst_n = 1; idle();
    expect_out("post_rst", 2'b00, 2'b00, 5'b00000, 0, 0, 0, 0, 1, 0, 0); tick();
    set_mem(1, 0);
    expect_out("post_rst_mem", 2'b00, 2'b00, 5'b00000, 0, 0, 1, 0, 0, 0, 0); tick();
    idle();

    for (int k = 0; k < 20 && sb_q.size() > 0; k++) @(posedge clk);
    if (sb_q.size() > 0) begin
      total++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
